// File: rtl/zif_vector_seq_if.sv
// Host byte-register bus and ZIF pin bundle shared by zif_vector_seq and its host.
// The slave modport is the sequencer side; master is the host/fixture side.
interface zif_vector_seq_if;
    logic        reg_wr;
    logic [7:0]  reg_addr;
    logic [7:0]  reg_wdata;
    logic [7:0]  reg_rdata;
    logic [47:0] zif_in;
    logic [47:0] zif_out;
    logic [47:0] zif_oe;
    logic        busy;
    logic        done;

    modport slave (
        input  reg_wr, reg_addr, reg_wdata, zif_in,
        output reg_rdata, zif_out, zif_oe, busy, done
    );

    modport master (
        output reg_wr, reg_addr, reg_wdata, zif_in,
        input  reg_rdata, zif_out, zif_oe, busy, done
    );
endinterface

// File: rtl/zif_vector_seq.sv
// ZIF vector sequencer: applies a host-loaded table of 48-pin drive vectors,
// waits a programmed settle time per vector and captures the pins into a result table.
module zif_vector_seq #(
    parameter int DEPTH    = 16,
    parameter int SETTLE_W = 8
) (
    input logic             osc,
    input logic             rst,
    zif_vector_seq_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, APPLY, SETTLE, SAMPLE} state_t;

    state_t              state_q;
    logic [AW-1:0]       ptr_q;
    logic [AW-1:0]       idx_q;
    logic [CW-1:0]       count_q;
    logic [SETTLE_W-1:0] settle_q;
    logic [SETTLE_W-1:0] cnt_q;
    logic [47:0]         zif_out_q;
    logic [47:0]         zif_oe_q;
    logic                busy_q;
    logic                done_q;
    logic                aborted_q;

    logic [47:0] vec_out_mem [DEPTH];
    logic [47:0] vec_oe_mem  [DEPTH];
    logic [47:0] result_mem  [DEPTH];

    logic          wr_ctrl;
    logic          start_req;
    logic          abort_req;
    logic          idle;
    logic          last_vec;
    logic [2:0]    byte_sel;
    logic          byte_ok;
    logic [CW-1:0] count_wr;
    logic [7:0]    rdata;

    assign byte_sel  = bus.reg_addr[2:0];
    assign byte_ok   = (byte_sel < 3'd6);
    assign idle      = (state_q == IDLE);
    assign wr_ctrl   = bus.reg_wr && (bus.reg_addr == 8'h20);
    // Abort has priority over a start carried in the same CTRL write.
    assign abort_req = wr_ctrl && bus.reg_wdata[1];
    assign start_req = wr_ctrl && bus.reg_wdata[0] && !bus.reg_wdata[1];
    assign last_vec  = ({1'b0, idx_q} == (count_q - CW'(1)));
    assign count_wr  = (int'(bus.reg_wdata) > DEPTH) ? CW'(DEPTH) : CW'(bus.reg_wdata);

    // Table storage carries no reset; contents are only meaningful once loaded or captured.
    always_ff @(posedge osc) begin
        if (bus.reg_wr && idle && byte_ok) begin
            if (bus.reg_addr[7:3] == 5'b00101)
                vec_out_mem[ptr_q][{byte_sel, 3'b000} +: 8] <= bus.reg_wdata;
            if (bus.reg_addr[7:3] == 5'b00110)
                vec_oe_mem[ptr_q][{byte_sel, 3'b000} +: 8] <= bus.reg_wdata;
        end
        if (!rst && (state_q == SAMPLE) && !abort_req)
            result_mem[idx_q] <= bus.zif_in;
    end

    always_ff @(posedge osc) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            idx_q     <= '0;
            count_q   <= '0;
            settle_q  <= '0;
            cnt_q     <= '0;
            zif_out_q <= '0;
            zif_oe_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            if (bus.reg_wr && (bus.reg_addr == 8'h21))
                ptr_q <= bus.reg_wdata[AW-1:0];
            if (bus.reg_wr && idle && (bus.reg_addr == 8'h22))
                count_q <= count_wr;
            if (bus.reg_wr && idle && (bus.reg_addr == 8'h23))
                settle_q <= SETTLE_W'(bus.reg_wdata);

            case (state_q)
                IDLE: begin
                    if (start_req && (count_q != '0)) begin
                        state_q   <= APPLY;
                        idx_q     <= '0;
                        busy_q    <= 1'b1;
                        done_q    <= 1'b0;
                        aborted_q <= 1'b0;
                    end
                end
                APPLY: begin
                    zif_out_q <= vec_out_mem[idx_q];
                    zif_oe_q  <= vec_oe_mem[idx_q];
                    cnt_q     <= settle_q;
                    state_q   <= (settle_q == '0) ? SAMPLE : SETTLE;
                end
                SETTLE: begin
                    if (cnt_q == SETTLE_W'(1))
                        state_q <= SAMPLE;
                    else
                        cnt_q <= cnt_q - SETTLE_W'(1);
                end
                SAMPLE: begin
                    if (last_vec) begin
                        state_q  <= IDLE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        zif_oe_q <= '0;
                    end else begin
                        idx_q   <= idx_q + AW'(1);
                        state_q <= APPLY;
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (abort_req && !idle) begin
                state_q   <= IDLE;
                busy_q    <= 1'b0;
                done_q    <= 1'b0;
                aborted_q <= 1'b1;
                zif_oe_q  <= '0;
            end
        end
    end

    always_comb begin
        rdata = 8'h00;
        case (bus.reg_addr)
            8'h20:   rdata = {5'b0, aborted_q, done_q, busy_q};
            8'h21:   rdata = 8'(ptr_q);
            8'h22:   rdata = 8'(count_q);
            8'h23:   rdata = 8'(settle_q);
            default: begin
                if ((bus.reg_addr[7:3] == 5'b00111) && byte_ok)
                    rdata = result_mem[ptr_q][{byte_sel, 3'b000} +: 8];
            end
        endcase
    end

    assign bus.reg_rdata = rdata;
    assign bus.zif_out   = zif_out_q;
    assign bus.zif_oe    = zif_oe_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule
